updown_ctrl: RTL
================

Name: updown_ctrl

Overview:
- Upstream control stage for the 4-bit up/down counter: turns two raw, bouncing push-buttons into a clean direction level (`updown`) and a count-enable strobe (`tick`).
- Per button: synchronises, debounces and edge-detects the input.
- The direction button toggles `updown`; the hold button toggles pause.
- A prescaler generates `tick` so the counter advances at a visible rate.

Parameters:
- DB_CYCLES, 16: consecutive stable synchronised samples required to accept a level change. Legal range ≥2.
- TICK_DIV, 10: clock cycles per `tick` pulse while running. Legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset, 1 = run).
- btn_dir  input  1  raw direction push-button, asynchronous, active-high.
- btn_hold  input  1  raw pause push-button, asynchronous, active-high.
- updown  output  1  count direction to the counter: 1 = up, 0 = down.
- tick  output  1  single-cycle count-enable strobe.
- paused  output  1  1 while counting is suspended.
- dir_changed  output  1  single-cycle pulse coincident with each `updown` toggle.

Behaviour:
- Reset (`rst`=0, asynchronous) forces:
  - `updown`=1, `paused`=0, `tick`=0, `dir_changed`=0;
  - synchronisers=0, debounce FSMs=IDLE, debounce counters=0, prescaler=0.
- Release is taken synchronously to `clk`.
- All outputs are registered.
- Synchronisers: each button passes through two flops; `s_dir` and `s_hold` are the second-flop outputs.
- Debounce FSM (one instance per button; counter `dbc` is wide enough for DB_CYCLES-1):
  - IDLE (accepted level 0):
    - `s`=1 → CONF_HI, `dbc`=0.
  - CONF_HI:
    - `s`=0 → IDLE.
    - else if `dbc`==DB_CYCLES-1 → HIGH and emit a one-cycle `press` pulse.
    - else `dbc`+1.
  - HIGH (accepted level 1):
    - `s`=0 → CONF_LO, `dbc`=0.
  - CONF_LO:
    - `s`=1 → HIGH.
    - else if `dbc`==DB_CYCLES-1 → IDLE, no pulse.
    - else `dbc`+1.
  - Any glitch shorter than DB_CYCLES samples produces no press.
  - A held button produces exactly one press; a new press requires release to IDLE first.
- Press latency:
  - Counting the first rising edge at which the raw button is sampled 1 as edge 1, with the button held stable:
    - `press` is internal and combinational from the FSM state; it goes high after edge DB_CYCLES+2.
    - The registered `updown`/`paused` change and `dir_changed` are visible after edge DB_CYCLES+3.
  - With DB_CYCLES=4 the outputs change after edge 7.
- Direction:
  - On `press_dir`: `updown` ← ~`updown` and `dir_changed`=1 for exactly one cycle.
  - Otherwise `dir_changed`=0.
  - `paused` does not gate direction changes.
- Pause: on `press_hold`, `paused` ← ~`paused`.
- Prescaler `pc`, range 0..TICK_DIV-1:
  - Running (`paused`=0):
    - `pc`==TICK_DIV-1 → `pc`=0 and `tick`=1 next cycle.
    - else `pc`+1 and `tick`=0.
  - Paused: `pc` holds its value and `tick`=0.
  - Resuming continues from the held `pc`; no extra or lost tick phase.
  - TICK_DIV=1: `tick`=1 every cycle while running.
- Simultaneous presses: both take effect on the same edge.
- Tick interaction:
  - A direction toggle never suppresses or duplicates a tick.
  - A tick in the same cycle as the toggle sees the new `updown`.
- Reset mid-debounce or mid-prescale: all progress is discarded. A button still held after release must be re-qualified for the full DB_CYCLES before it counts as a press.

Test Plan (DB_CYCLES=4, TICK_DIV=3, 10 ns clock):
- Reset then idle:
  - Stimulus: `rst`=0 for 10 ns, then 1, buttons 0.
  - Required: `updown`=1 and `paused`=0 throughout.
  - Required: `tick` high for one cycle every 3 cycles, first after the 3rd edge following release.
- Clean dir press:
  - Stimulus: `btn_dir`=1 held 100 ns.
  - Required: `updown` 1→0 after edge 7; `dir_changed` high for exactly that one cycle; no further toggle while held.
  - Stimulus: second press after release.
  - Required: `updown` returns to 1.
- Bounce rejection:
  - Stimulus: `btn_dir` toggles 1/0 every 20 ns for 100 ns, then held 1.
  - Required: exactly one `updown` toggle, occurring 7 edges after the stable high begins.
- Pause/resume:
  - Stimulus: press `btn_hold` when `pc`=1.
  - Required: `tick` stays 0 while paused.
  - Stimulus: second press.
  - Required: next tick arrives 1 cycle after resume, i.e. `pc` resumes from its held value.
- Simultaneous presses:
  - Stimulus: `btn_dir` and `btn_hold` rise on the same edge.
  - Required: `updown` and `paused` both toggle on the same edge.
- Reset mid-debounce:
  - Stimulus: assert `rst`=0 for 10 ns while `btn_dir` is 1 and in CONF_HI; keep the button held.
  - Required: outputs return to reset values immediately.
  - Required: the toggle occurs a full 7 edges after release, not earlier.

Source files
------------

// File: rtl/updown_ctrl.sv
// Button front-end for the up/down counter: synchronises and debounces the
// direction and pause buttons, and generates the prescaled count-enable tick.

module DebounceFsm #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic s_i,
    output logic press_o
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DBC_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CONF_HI, HIGH, CONF_LO} dbState_t;

    dbState_t       state_q, state_d;
    logic [DBW-1:0] dbc_q, dbc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dbc_q   <= '0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        unique case (state_q)
            IDLE: begin
                if (s_i) begin
                    state_d = CONF_HI;
                    dbc_d   = '0;
                end
            end
            CONF_HI: begin
                if (!s_i)                  state_d = IDLE;
                else if (dbc_q == DBC_LAST) state_d = HIGH;
                else                       dbc_d   = dbc_q + DBW'(1);
            end
            HIGH: begin
                if (!s_i) begin
                    state_d = CONF_LO;
                    dbc_d   = '0;
                end
            end
            CONF_LO: begin
                if (s_i)                   state_d = HIGH;
                else if (dbc_q == DBC_LAST) state_d = IDLE;
                else                       dbc_d   = dbc_q + DBW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // The press fires only on the qualifying CONF_HI -> HIGH transition.
    always_comb begin
        press_o = (state_q == CONF_HI) && s_i && (dbc_q == DBC_LAST);
    end

endmodule

module updown_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int TICK_DIV  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_dir,
    input  logic btn_hold,
    output logic updown,
    output logic tick,
    output logic paused,
    output logic dir_changed
);

    localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(TICK_DIV - 1);

    logic           dir_meta_q, dir_sync_q, hold_meta_q, hold_sync_q;
    logic           press_dir, press_hold;
    logic [PCW-1:0] pc_q, pc_d;
    logic           updown_q, updown_d, paused_q, paused_d;
    logic           tick_q, tick_d, dir_changed_q, dir_changed_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_meta_q  <= 1'b0;
            dir_sync_q  <= 1'b0;
            hold_meta_q <= 1'b0;
            hold_sync_q <= 1'b0;
        end else begin
            dir_meta_q  <= btn_dir;
            dir_sync_q  <= dir_meta_q;
            hold_meta_q <= btn_hold;
            hold_sync_q <= hold_meta_q;
        end
    end

    DebounceFsm #(.DB_CYCLES(DB_CYCLES)) u_dbDir (
        .clk     (clk),
        .rst     (rst),
        .s_i     (dir_sync_q),
        .press_o (press_dir)
    );

    DebounceFsm #(.DB_CYCLES(DB_CYCLES)) u_dbHold (
        .clk     (clk),
        .rst     (rst),
        .s_i     (hold_sync_q),
        .press_o (press_hold)
    );

    // The prescaler is gated by the registered pause level, so it freezes with
    // pc intact and resumes on the same phase.
    always_comb begin
        pc_d          = pc_q;
        tick_d        = 1'b0;
        updown_d      = updown_q ^ press_dir;
        dir_changed_d = press_dir;
        paused_d      = paused_q ^ press_hold;
        if (!paused_q) begin
            if (pc_q == PC_LAST) begin
                pc_d   = '0;
                tick_d = 1'b1;
            end else begin
                pc_d   = pc_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= '0;
            tick_q        <= 1'b0;
            updown_q      <= 1'b1;
            paused_q      <= 1'b0;
            dir_changed_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            tick_q        <= tick_d;
            updown_q      <= updown_d;
            paused_q      <= paused_d;
            dir_changed_q <= dir_changed_d;
        end
    end

    assign updown      = updown_q;
    assign tick        = tick_q;
    assign paused      = paused_q;
    assign dir_changed = dir_changed_q;

endmodule
